llc_mem_responder: RTL and testbench
====================================

LLC_MEM_RESPONDER -- requirements
Module: llc_mem_responder

Interface
REQ-001 SHALL have parameter MEM_LINES_LOG2, default 6, log2 of backing-store depth in lines.
REQ-002 SHALL have parameter RD_LATENCY, default 4, cycles from read acceptance to rsp_valid; legal range 1..15.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port llc_mem_req_valid  in  1  request present.
REQ-006 SHALL have port llc_mem_req_ready  out  1  request accepted when valid&ready.
REQ-007 SHALL have port llc_mem_req_hwrite  in  1  1=line write, 0=line read.
REQ-008 SHALL have ports llc_mem_req_hsize  in  HSIZE_WIDTH, and llc_mem_req_hprot  in  HPROT_WIDTH; both accepted and ignored.
REQ-009 SHALL have port llc_mem_req_addr  in  LINE_ADDR_BITS  line address.
REQ-010 SHALL have port llc_mem_req_line  in  BITS_PER_LINE  write data.
REQ-011 SHALL have port llc_mem_rsp_valid  out  1  read data present.
REQ-012 SHALL have port llc_mem_rsp_ready  in  1  consumer accepts when valid&ready.
REQ-013 SHALL have port llc_mem_rsp_line  out  BITS_PER_LINE  read data.
REQ-014 SHALL have port mem_err  out  1  sticky out-of-range flag; present only with LLC_MEM_ERR_EN.

Function
REQ-015 SHALL implement an FSM with states IDLE, READ_WAIT, RSP.
REQ-016 In IDLE, llc_mem_req_ready SHALL be 1; in READ_WAIT and RSP it SHALL be 0.
REQ-017 On a write handshake, the full line SHALL be stored at the indexed entry at that clock edge; the FSM SHALL stay in IDLE, allowing one write per cycle with no response.
REQ-018 On a read handshake at edge T, the FSM SHALL latch the address and load counter RD_LATENCY-1; it SHALL go to RSP if RD_LATENCY=1, else to READ_WAIT.
REQ-019 In READ_WAIT, the counter SHALL decrement each cycle; on reaching 0 the FSM SHALL enter RSP, so that rsp_valid first asserts in cycle T+RD_LATENCY.
REQ-020 Read data SHALL be sampled from the array on entry to RSP; a read issued the cycle after a write to the same line SHALL return the new data.
REQ-021 In RSP, rsp_valid SHALL be 1 and rsp_line SHALL be held stable until the rsp handshake; on handshake the FSM SHALL return to IDLE, with req_ready=1 in the following cycle.
REQ-022 rsp_ready asserted without rsp_valid SHALL have no effect; rsp_valid SHALL never depend combinationally on rsp_ready.
REQ-023 Array index SHALL be addr[MEM_LINES_LOG2-1:0] when LLC_MEM_ERR_EN is undefined; upper address bits alias (wrap-around).
REQ-024 At most one read SHALL be outstanding; no request queuing.

Reset
REQ-025 When rst=1 at a clock edge, the FSM SHALL go to IDLE, the counter to 0, rsp_valid to 0, rsp_line to 0, and mem_err to 0.
REQ-026 Reset mid-read SHALL drop the in-flight read with no response; array contents SHALL be unaffected by reset and undefined after power-up.
REQ-027 While rst=1, req_ready SHALL be 0.

Configuration
REQ-028 Macro LLC_MEM_ERR_EN SHALL enable range checking: an address with any nonzero bit above MEM_LINES_LOG2-1 SHALL be out of range.
REQ-029 With LLC_MEM_ERR_EN, an out-of-range write SHALL be dropped, an out-of-range read SHALL return an all-zero line with normal latency, and either SHALL set mem_err, which stays 1 until reset.
REQ-030 Without LLC_MEM_ERR_EN, the mem_err port and its logic SHALL be absent, and REQ-023 aliasing SHALL apply.

Verification
REQ-031 Write addr 0x05 line 0xA5..A5, then read 0x05 with rsp_ready=1 -> rsp_valid exactly 4 cycles after read acceptance, line 0xA5..A5, req_ready=1 next cycle.
REQ-032 Write 0x03 then read 0x03 on the next cycle -> new data returned (read-after-write).
REQ-033 Read 0x05 with rsp_ready held 0 for 10 cycles -> rsp_valid stays 1, line stable, req_valid ignored (ready=0); raise rsp_ready -> single handshake.
REQ-034 Assert rst 2 cycles after read acceptance -> no rsp_valid ever for that read; req_ready=1 the cycle after rst deasserts.
REQ-035 With RD_LATENCY=1, back-to-back reads of 0x01 and 0x02 with rsp_ready=1 -> responses in order, each one cycle after acceptance.
REQ-036 With LLC_MEM_ERR_EN and MEM_LINES_LOG2=6, write 0x40 then read 0x40 -> mem_err=1, returned line all zeros, entry 0x00 unchanged; without the macro, 0x40 aliases to entry 0x00.

Source files
------------

// File: rtl/llc_mem_responder_if.sv
// ----------------------------------------------------------------------------
// llc_mem_responder_if
// Request/response bundle between the last-level cache and its memory
// responder.
//   request  : llc_mem_req_valid/ready handshake, hwrite (1=line write,
//              0=line read), hsize/hprot (carried, unused by the responder),
//              line address and write line
//   response : llc_mem_rsp_valid/ready handshake and the read line
// Modports: master = cache side (drives requests), slave = responder side.
// ----------------------------------------------------------------------------
interface llc_mem_responder_if #(
   parameter int LINE_ADDR_BITS = 8,
   parameter int BITS_PER_LINE  = 128,
   parameter int HSIZE_WIDTH    = 3,
   parameter int HPROT_WIDTH    = 2
);
   logic                      llc_mem_req_valid;
   logic                      llc_mem_req_ready;
   logic                      llc_mem_req_hwrite;
   logic [HSIZE_WIDTH-1:0]    llc_mem_req_hsize;
   logic [HPROT_WIDTH-1:0]    llc_mem_req_hprot;
   logic [LINE_ADDR_BITS-1:0] llc_mem_req_addr;
   logic [BITS_PER_LINE-1:0]  llc_mem_req_line;
   logic                      llc_mem_rsp_valid;
   logic                      llc_mem_rsp_ready;
   logic [BITS_PER_LINE-1:0]  llc_mem_rsp_line;

   modport master (
      output llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_hsize,
             llc_mem_req_hprot, llc_mem_req_addr, llc_mem_req_line,
             llc_mem_rsp_ready,
      input  llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line
   );

   modport slave (
      input  llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_hsize,
             llc_mem_req_hprot, llc_mem_req_addr, llc_mem_req_line,
             llc_mem_rsp_ready,
      output llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line
   );
endinterface

// File: rtl/llc_mem_responder.sv
// ----------------------------------------------------------------------------
// llc_mem_responder
// Line-granular backing store behind the LLC. Writes complete in one cycle
// with no response; a read returns its line RD_LATENCY cycles after
// acceptance and holds it until the consumer takes it. One read at a time.
//
// Ports
//   clk     : sole clock, rising edge
//   rst     : synchronous, active-high reset
//   bus     : llc_mem_responder_if.slave (request + response handshakes)
//   mem_err : sticky out-of-range flag (only with LLC_MEM_ERR_EN)
//
// Optional feature: define LLC_MEM_ERR_EN to range-check addresses. Out-of-
// range writes are dropped, out-of-range reads return zeros, and either sets
// mem_err until reset. Without it, upper address bits alias onto the array.
//
// RD_LATENCY must lie in 1..15 (the wait counter is 4 bits wide).
// ----------------------------------------------------------------------------
module llc_mem_responder #(
   parameter int MEM_LINES_LOG2 = 6,
   parameter int RD_LATENCY     = 4,
   parameter int LINE_ADDR_BITS = 8,
   parameter int BITS_PER_LINE  = 128
) (
   input  logic                clk,
   input  logic                rst,
   llc_mem_responder_if.slave  bus
`ifdef LLC_MEM_ERR_EN
   ,
   output logic                mem_err
`endif
);

   localparam int DEPTH = 1 << MEM_LINES_LOG2;

   typedef enum logic [1:0] {IDLE, READ_WAIT, RSP} state_e;

   state_e                    state_q;
   logic [3:0]                cnt_q;
   logic [MEM_LINES_LOG2-1:0] rd_idx_q;
   logic                      rsp_valid_q;
   logic [BITS_PER_LINE-1:0]  rsp_line_q;
   logic [BITS_PER_LINE-1:0]  rd_line_d;
   logic [BITS_PER_LINE-1:0]  mem_q [DEPTH];

   logic                      req_ready;
   logic                      wr_fire;
   logic                      rd_fire;
   logic                      wr_en;
   logic [MEM_LINES_LOG2-1:0] req_idx;
   logic                      unused_bits;

   // hsize/hprot are accepted but carry no meaning here.
   assign unused_bits = ^{bus.llc_mem_req_hsize, bus.llc_mem_req_hprot,
                          bus.llc_mem_req_addr};

   // Ready is a pure decode of state, forced low while reset is held so no
   // request can slip in during reset.
   assign req_ready = (state_q == IDLE) && !rst;
   assign wr_fire   = bus.llc_mem_req_valid && req_ready &&  bus.llc_mem_req_hwrite;
   assign rd_fire   = bus.llc_mem_req_valid && req_ready && !bus.llc_mem_req_hwrite;
   assign req_idx   = bus.llc_mem_req_addr[MEM_LINES_LOG2-1:0];

`ifdef LLC_MEM_ERR_EN
   logic req_oor;
   logic rd_oor_q;
   logic mem_err_q;

   assign req_oor = |bus.llc_mem_req_addr[LINE_ADDR_BITS-1:MEM_LINES_LOG2];
   assign wr_en   = wr_fire && !req_oor;
   assign mem_err = mem_err_q;
`else
   assign wr_en   = wr_fire;
`endif

   // Line to load into the response register. With RD_LATENCY=1 the RSP
   // entry happens on the acceptance edge, so the index comes straight from
   // the request; otherwise from the latched address.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      rd_line_d = mem_q[(state_q == IDLE) ? req_idx : rd_idx_q];
`ifdef LLC_MEM_ERR_EN
      if ((state_q == IDLE) ? req_oor : rd_oor_q) begin
         rd_line_d = '0;
      end
`endif
   end

   // NOTE: the array has no reset; its contents survive rst and are
   // undefined after power-up, which keeps it mappable onto RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[req_idx] <= bus.llc_mem_req_line;
      end
   end

   // Control FSM with registered response outputs.
   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_line_q  <= '0;
`ifdef LLC_MEM_ERR_EN
         mem_err_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (rd_fire) begin
                  rd_idx_q <= req_idx;
`ifdef LLC_MEM_ERR_EN
                  rd_oor_q <= req_oor;
`endif
                  if (RD_LATENCY == 1) begin
                     state_q     <= RSP;
                     cnt_q       <= '0;
                     rsp_valid_q <= 1'b1;
                     rsp_line_q  <= rd_line_d;
                  end else begin
                     state_q <= READ_WAIT;
                     cnt_q   <= 4'(RD_LATENCY - 1);
                  end
               end
            end
            READ_WAIT: begin
               // Counter reaching zero on this edge means the response
               // becomes visible exactly RD_LATENCY cycles after acceptance.
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q     <= RSP;
                  rsp_valid_q <= 1'b1;
                  rsp_line_q  <= rd_line_d;
               end
            end
            RSP: begin
               if (bus.llc_mem_rsp_ready) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
`ifdef LLC_MEM_ERR_EN
         if ((wr_fire || rd_fire) && req_oor) begin
            mem_err_q <= 1'b1;
         end
`endif
      end
   end

   assign bus.llc_mem_req_ready = req_ready;
   assign bus.llc_mem_rsp_valid = rsp_valid_q;
   assign bus.llc_mem_rsp_line  = rsp_line_q;

endmodule

// File: tb/tb_llc_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_llc_mem_responder
// Two responders: dut_a with the default 4-cycle read latency, dut_b with
// latency 1. A reference store (associative array of entry -> line) predicts
// read data from the addressing rules; latencies and handshake behaviour are
// compared against constants derived from the block's behaviour.
// ----------------------------------------------------------------------------
module tb_llc_mem_responder;

   localparam int AW    = 8;
   localparam int LW    = 128;
   localparam int ML    = 6;
   localparam int LAT_A = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   llc_mem_responder_if #(.LINE_ADDR_BITS(AW), .BITS_PER_LINE(LW)) if_a ();
   llc_mem_responder_if #(.LINE_ADDR_BITS(AW), .BITS_PER_LINE(LW)) if_b ();

`ifdef LLC_MEM_ERR_EN
   logic err_a;
   logic err_b;
`endif

   llc_mem_responder #(
      .MEM_LINES_LOG2(ML), .RD_LATENCY(LAT_A),
      .LINE_ADDR_BITS(AW), .BITS_PER_LINE(LW)
   ) dut_a (
      .clk(clk),
      .rst(rst),
      .bus(if_a)
`ifdef LLC_MEM_ERR_EN
      ,
      .mem_err(err_a)
`endif
   );

   llc_mem_responder #(
      .MEM_LINES_LOG2(ML), .RD_LATENCY(1),
      .LINE_ADDR_BITS(AW), .BITS_PER_LINE(LW)
   ) dut_b (
      .clk(clk),
      .rst(rst),
      .bus(if_b)
`ifdef LLC_MEM_ERR_EN
      ,
      .mem_err(err_b)
`endif
   );

   int total = 0;
   int bad   = 0;

   // Reference store for dut_a: entry index -> last line written there.
   logic [LW-1:0] model [int];
   bit            seen_oor = 1'b0;

   function automatic int entry(input logic [AW-1:0] a);
      return int'(a) % (1 << ML);
   endfunction

   function automatic bit oor(input logic [AW-1:0] a);
`ifdef LLC_MEM_ERR_EN
      return int'(a) >= (1 << ML);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [LW-1:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [LW-1:0] expect_line(input logic [AW-1:0] a);
      if (oor(a)) return '0;
      return model[entry(a)];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready_a();
      int n = 0;
      while (!if_a.llc_mem_req_ready && n < 100) begin
         step();
         n++;
      end
      total++;
      if (n >= 100) begin
         bad++;
         $display("FAIL ready_timeout: req_ready got %b want 1 within 100 cycles",
                  if_a.llc_mem_req_ready);
      end
   endtask

   task automatic write_a(input logic [AW-1:0] addr, input logic [LW-1:0] line);
      wait_ready_a();
      if_a.llc_mem_req_valid  = 1'b1;
      if_a.llc_mem_req_hwrite = 1'b1;
      if_a.llc_mem_req_hsize  = 3'($urandom);
      if_a.llc_mem_req_hprot  = 2'($urandom);
      if_a.llc_mem_req_addr   = addr;
      if_a.llc_mem_req_line   = line;
      step();
      if_a.llc_mem_req_valid  = 1'b0;
      if (oor(addr)) seen_oor = 1'b1;
      else           model[entry(addr)] = line;
   endtask

   // Issues a read and waits for rsp_valid; returns the cycle count from
   // acceptance (1 = valid in the cycle right after the acceptance edge).
   task automatic read_a(input logic [AW-1:0] addr, output logic [LW-1:0] line,
                         output int lat);
      wait_ready_a();
      if_a.llc_mem_req_valid  = 1'b1;
      if_a.llc_mem_req_hwrite = 1'b0;
      if_a.llc_mem_req_addr   = addr;
      if_a.llc_mem_req_line   = rand_line();
      step();
      if_a.llc_mem_req_valid  = 1'b0;
      if (oor(addr)) seen_oor = 1'b1;
      lat = 1;
      while (!if_a.llc_mem_rsp_valid && lat < 40) begin
         step();
         lat++;
      end
      line = if_a.llc_mem_rsp_line;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      if_a.llc_mem_req_valid = 1'b0; if_a.llc_mem_rsp_ready = 1'b0;
      if_a.llc_mem_req_hwrite = 1'b0; if_a.llc_mem_req_addr = '0;
      if_a.llc_mem_req_line = '0; if_a.llc_mem_req_hsize = '0; if_a.llc_mem_req_hprot = '0;
      if_b.llc_mem_req_valid = 1'b0; if_b.llc_mem_rsp_ready = 1'b0;
      if_b.llc_mem_req_hwrite = 1'b0; if_b.llc_mem_req_addr = '0;
      if_b.llc_mem_req_line = '0; if_b.llc_mem_req_hsize = '0; if_b.llc_mem_req_hprot = '0;
      repeat (3) step();
      total++;
      if (if_a.llc_mem_req_ready !== 1'b0) begin
         bad++; $display("FAIL reset_ready: got %b want 0", if_a.llc_mem_req_ready);
      end
      total++;
      if (if_a.llc_mem_rsp_valid !== 1'b0) begin
         bad++; $display("FAIL reset_rsp_valid: got %b want 0", if_a.llc_mem_rsp_valid);
      end
      total++;
      if (if_a.llc_mem_rsp_line !== '0) begin
         bad++; $display("FAIL reset_rsp_line: got %h want 0", if_a.llc_mem_rsp_line);
      end
      total++;
      if (if_b.llc_mem_rsp_valid !== 1'b0) begin
         bad++; $display("FAIL reset_rsp_valid_b: got %b want 0", if_b.llc_mem_rsp_valid);
      end
`ifdef LLC_MEM_ERR_EN
      total++;
      if (err_a !== 1'b0) begin
         bad++; $display("FAIL reset_mem_err: got %b want 0", err_a);
      end
`endif
      rst = 1'b0;
      #1;
      total++;
      if (if_a.llc_mem_req_ready !== 1'b1) begin
         bad++; $display("FAIL post_reset_ready: got %b want 1", if_a.llc_mem_req_ready);
      end
   endtask

   task automatic test_basic();
      logic [LW-1:0] line;
      int            lat;
      write_a(8'h05, {16{8'hA5}});
      if_a.llc_mem_rsp_ready = 1'b1;
      read_a(8'h05, line, lat);
      total++;
      if (lat != LAT_A) begin
         bad++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT_A);
      end
      total++;
      if (line !== {16{8'hA5}}) begin
         bad++; $display("FAIL basic_line: got %h want %h", line, {16{8'hA5}});
      end
      total++;
      if (if_a.llc_mem_req_ready !== 1'b0) begin
         bad++; $display("FAIL basic_busy_ready: got %b want 0", if_a.llc_mem_req_ready);
      end
      step();
      total++;
      if (if_a.llc_mem_rsp_valid !== 1'b0 || if_a.llc_mem_req_ready !== 1'b1) begin
         bad++;
         $display("FAIL basic_after_hs: valid/ready got %b/%b want 0/1",
                  if_a.llc_mem_rsp_valid, if_a.llc_mem_req_ready);
      end
   endtask

   task automatic test_raw();
      logic [LW-1:0] line;
      logic [LW-1:0] newer;
      int            lat;
      newer = rand_line();
      write_a(8'h03, rand_line());
      write_a(8'h03, newer);
      if_a.llc_mem_rsp_ready = 1'b1;
      read_a(8'h03, line, lat);
      total++;
      if (line !== newer) begin
         bad++; $display("FAIL raw_line: got %h want %h", line, newer);
      end
      step();
   endtask

   task automatic test_backpressure();
      logic [LW-1:0] line;
      int            lat;
      if_a.llc_mem_rsp_ready = 1'b0;
      read_a(8'h05, line, lat);
      total++;
      if (lat != LAT_A || line !== {16{8'hA5}}) begin
         bad++;
         $display("FAIL bp_first: lat %0d line %h want %0d %h", lat, line, LAT_A, {16{8'hA5}});
      end
      // Attempted write while the response is pending must be ignored.
      if_a.llc_mem_req_valid  = 1'b1;
      if_a.llc_mem_req_hwrite = 1'b1;
      if_a.llc_mem_req_addr   = 8'h05;
      if_a.llc_mem_req_line   = {16{8'h5A}};
      for (int i = 0; i < 10; i++) begin
         total++;
         if (if_a.llc_mem_rsp_valid !== 1'b1 || if_a.llc_mem_rsp_line !== {16{8'hA5}} ||
             if_a.llc_mem_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold[%0d]: valid %b ready %b line %h want 1 0 %h", i,
                     if_a.llc_mem_rsp_valid, if_a.llc_mem_req_ready,
                     if_a.llc_mem_rsp_line, {16{8'hA5}});
         end
         step();
      end
      if_a.llc_mem_req_valid = 1'b0;
      if_a.llc_mem_rsp_ready = 1'b1;
      step();
      total++;
      if (if_a.llc_mem_rsp_valid !== 1'b0 || if_a.llc_mem_req_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_release: valid/ready got %b/%b want 0/1",
                  if_a.llc_mem_rsp_valid, if_a.llc_mem_req_ready);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if (if_a.llc_mem_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL bp_single[%0d]: rsp_valid got %b want 0", i, if_a.llc_mem_rsp_valid);
         end
      end
      read_a(8'h05, line, lat);
      total++;
      if (line !== {16{8'hA5}}) begin
         bad++; $display("FAIL bp_write_ignored: got %h want %h", line, {16{8'hA5}});
      end
      step();
   endtask

   task automatic test_reset_mid_read();
      logic [LW-1:0] line;
      int            lat;
      if_a.llc_mem_rsp_ready = 1'b1;
      wait_ready_a();
      if_a.llc_mem_req_valid  = 1'b1;
      if_a.llc_mem_req_hwrite = 1'b0;
      if_a.llc_mem_req_addr   = 8'h05;
      step();
      if_a.llc_mem_req_valid  = 1'b0;
      step();
      rst = 1'b1;
      #1;
      total++;
      if (if_a.llc_mem_req_ready !== 1'b0) begin
         bad++; $display("FAIL rst_mid_ready: got %b want 0", if_a.llc_mem_req_ready);
      end
      step();
      rst = 1'b0;
      #1;
      total++;
      if (if_a.llc_mem_req_ready !== 1'b1 || if_a.llc_mem_rsp_line !== '0) begin
         bad++;
         $display("FAIL rst_mid_after: ready %b line %h want 1 0",
                  if_a.llc_mem_req_ready, if_a.llc_mem_rsp_line);
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (if_a.llc_mem_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rst_mid_dropped[%0d]: rsp_valid got %b want 0", i, if_a.llc_mem_rsp_valid);
         end
         step();
      end
      // Array contents survive reset.
      read_a(8'h05, line, lat);
      total++;
      if (line !== {16{8'hA5}}) begin
         bad++; $display("FAIL rst_mid_array: got %h want %h", line, {16{8'hA5}});
      end
      step();
   endtask

   task automatic test_latency1();
      logic [LW-1:0] d1;
      logic [LW-1:0] d2;
      d1 = rand_line();
      d2 = rand_line();
      if_b.llc_mem_req_valid  = 1'b1;
      if_b.llc_mem_req_hwrite = 1'b1;
      if_b.llc_mem_req_addr   = 8'h01;
      if_b.llc_mem_req_line   = d1;
      step();
      if_b.llc_mem_req_addr   = 8'h02;
      if_b.llc_mem_req_line   = d2;
      step();
      if_b.llc_mem_rsp_ready  = 1'b1;
      if_b.llc_mem_req_hwrite = 1'b0;
      if_b.llc_mem_req_addr   = 8'h01;
      step();
      total++;
      if (if_b.llc_mem_rsp_valid !== 1'b1 || if_b.llc_mem_rsp_line !== d1) begin
         bad++;
         $display("FAIL lat1_first: valid %b line %h want 1 %h",
                  if_b.llc_mem_rsp_valid, if_b.llc_mem_rsp_line, d1);
      end
      if_b.llc_mem_req_addr = 8'h02;
      step();
      total++;
      if (if_b.llc_mem_req_ready !== 1'b1 || if_b.llc_mem_rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL lat1_gap: ready/valid got %b/%b want 1/0",
                  if_b.llc_mem_req_ready, if_b.llc_mem_rsp_valid);
      end
      step();
      if_b.llc_mem_req_valid = 1'b0;
      total++;
      if (if_b.llc_mem_rsp_valid !== 1'b1 || if_b.llc_mem_rsp_line !== d2) begin
         bad++;
         $display("FAIL lat1_second: valid %b line %h want 1 %h",
                  if_b.llc_mem_rsp_valid, if_b.llc_mem_rsp_line, d2);
      end
      step();
      total++;
      if (if_b.llc_mem_rsp_valid !== 1'b0) begin
         bad++; $display("FAIL lat1_done: rsp_valid got %b want 0", if_b.llc_mem_rsp_valid);
      end
   endtask

   task automatic test_range();
      logic [LW-1:0] x;
      logic [LW-1:0] y;
      logic [LW-1:0] line;
      int            lat;
      x = rand_line();
      y = rand_line();
      if_a.llc_mem_rsp_ready = 1'b1;
      write_a(8'h00, y);
      write_a(8'h40, x);
      read_a(8'h40, line, lat);
      step();
      total++;
      if (lat != LAT_A) begin
         bad++; $display("FAIL range_latency: got %0d want %0d", lat, LAT_A);
      end
`ifdef LLC_MEM_ERR_EN
      total++;
      if (line !== '0) begin
         bad++; $display("FAIL range_oor_line: got %h want 0", line);
      end
      total++;
      if (err_a !== 1'b1) begin
         bad++; $display("FAIL range_mem_err: got %b want 1", err_a);
      end
      read_a(8'h00, line, lat);
      step();
      total++;
      if (line !== y) begin
         bad++; $display("FAIL range_entry0: got %h want %h", line, y);
      end
`else
      total++;
      if (line !== x) begin
         bad++; $display("FAIL range_alias_line: got %h want %h", line, x);
      end
      read_a(8'h00, line, lat);
      step();
      total++;
      if (line !== x) begin
         bad++; $display("FAIL range_alias_entry0: got %h want %h", line, x);
      end
`endif
   endtask

   task automatic test_random();
      logic [LW-1:0] line;
      logic [LW-1:0] want;
      logic [AW-1:0] addr;
      int            lat;
      int            hold;
      if_a.llc_mem_rsp_ready = 1'b1;
      for (int e = 0; e < (1 << ML); e++) write_a(AW'(e), rand_line());
      for (int n = 0; n < 200; n++) begin
         addr = AW'($urandom);
         if ($urandom_range(0, 9) < 5) begin
            write_a(addr, rand_line());
         end else begin
            want = expect_line(addr);
            hold = $urandom_range(0, 3);
            if_a.llc_mem_rsp_ready = (hold == 0);
            read_a(addr, line, lat);
            total++;
            if (lat != LAT_A || line !== want) begin
               bad++;
               $display("FAIL rand_read[%0d] addr %h: lat %0d line %h want %0d %h",
                        n, addr, lat, line, LAT_A, want);
            end
            for (int h = 0; h < hold; h++) begin
               step();
               total++;
               if (if_a.llc_mem_rsp_valid !== 1'b1 || if_a.llc_mem_rsp_line !== want ||
                   if_a.llc_mem_req_ready !== 1'b0) begin
                  bad++;
                  $display("FAIL rand_hold[%0d]: valid %b ready %b line %h want 1 0 %h", n,
                           if_a.llc_mem_rsp_valid, if_a.llc_mem_req_ready,
                           if_a.llc_mem_rsp_line, want);
               end
            end
            if_a.llc_mem_rsp_ready = 1'b1;
            step();
            total++;
            if (if_a.llc_mem_rsp_valid !== 1'b0 || if_a.llc_mem_req_ready !== 1'b1) begin
               bad++;
               $display("FAIL rand_release[%0d]: valid/ready got %b/%b want 0/1", n,
                        if_a.llc_mem_rsp_valid, if_a.llc_mem_req_ready);
            end
         end
      end
`ifdef LLC_MEM_ERR_EN
      total++;
      if (err_a !== seen_oor) begin
         bad++; $display("FAIL rand_mem_err: got %b want %b", err_a, seen_oor);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_raw();
      test_backpressure();
      test_reset_mid_read();
      test_latency1();
      test_range();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
